// File: rtl/btn_conditioner_pkg.sv
// Shared types and constants for the push-button conditioner.
package btn_conditioner_pkg;

  typedef enum logic {
    STABLE_LOW  = 1'b0,
    STABLE_HIGH = 1'b1
  } btn_state_t;

  // 10 ms of stability at the 100 MHz board clock
  localparam int DEBOUNCE_DEFAULT = 1_000_000;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle: raw levels in, debounced level and press/release pulses out.
interface btn_conditioner_if #(
  parameter int N_BTN = 3
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  modport master (output btn_in, input btn_level, btn_press, btn_release);
  modport slave  (input btn_in, output btn_level, btn_press, btn_release);
endinterface

// File: rtl/btn_conditioner_debounce_ch.sv
// One button channel: 2-flop synchronizer, stability counter, level FSM and
// registered press/release pulses.
module btn_debounce_ch
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  btn_state_t       state, state_nxt;
  logic             press_nxt, rel_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      state <= STABLE_LOW;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      cnt   <= cnt_nxt;
      state <= state_nxt;
      press <= press_nxt;
      rel   <= rel_nxt;
    end
  end

  // A mismatch that survives CNT_LAST+1 consecutive edges flips the state;
  // any agreement with the accepted level clears the count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (s2) begin
          if (cnt == CNT_LAST) begin
            state_nxt = STABLE_HIGH;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      STABLE_HIGH: begin
        if (!s2) begin
          if (cnt == CNT_LAST) begin
            state_nxt = STABLE_LOW;
            rel_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = STABLE_LOW;
    endcase
  end

  assign level = (state == STABLE_HIGH);

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN independent push buttons into clean levels and
// single-cycle press/release pulses.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  btn_conditioner_if.slave  bus
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .CLK  (CLK),
      .RST  (RST),
      .btn  (bus.btn_in[i]),
      .level(bus.btn_level[i]),
      .press(bus.btn_press[i]),
      .rel  (bus.btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4; expected
// outputs are written per edge relative to the edge that first samples btn_in.
module tb_btn_conditioner;

  logic CLK;
  logic RST;
  int   vectors;
  int   miscompares;

  btn_conditioner_if #(.N_BTN(3)) bus ();

  btn_conditioner #(
    .N_BTN          (3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    bus.btn_in = 3'b000;
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.btn_in = 3'b111;
    for (int e = 0; e < 4; e++) begin
      tick();
      vectors++;
      if (bus.btn_level !== 3'b000 || bus.btn_press !== 3'b000 || bus.btn_release !== 3'b000) begin
        miscompares++;
        $display("FAIL reset e=%0d level=%b press=%b release=%b required all 000",
                 e, bus.btn_level, bus.btn_press, bus.btn_release);
      end
    end
    RST = 1'b0;
    bus.btn_in = 3'b000;
  endtask

  task automatic test_clean_press();
    logic [2:0] exp_l, exp_p;
    do_reset();
    bus.btn_in = 3'b010;
    for (int e = 0; e <= 20; e++) begin
      tick();
      exp_l = (e >= 5) ? 3'b010 : 3'b000;
      exp_p = (e == 5) ? 3'b010 : 3'b000;
      vectors++;
      if (bus.btn_level !== exp_l || bus.btn_press !== exp_p || bus.btn_release !== 3'b000) begin
        miscompares++;
        $display("FAIL clean_press e=%0d level=%b req %b press=%b req %b release=%b req 000",
                 e, bus.btn_level, exp_l, bus.btn_press, exp_p, bus.btn_release);
      end
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pattern;
    logic [2:0] exp_l, exp_p;
    pattern = 6'b101011;  // bit j drives edge j: 1,1,0,1,0,1
    do_reset();
    for (int e = 0; e <= 20; e++) begin
      bus.btn_in = {2'b00, (e < 6) ? pattern[e] : 1'b1};
      tick();
      exp_l = (e >= 10) ? 3'b001 : 3'b000;
      exp_p = (e == 10) ? 3'b001 : 3'b000;
      vectors++;
      if (bus.btn_level !== exp_l || bus.btn_press !== exp_p || bus.btn_release !== 3'b000) begin
        miscompares++;
        $display("FAIL bounce e=%0d level=%b req %b press=%b req %b release=%b req 000",
                 e, bus.btn_level, exp_l, bus.btn_press, exp_p, bus.btn_release);
      end
    end
  endtask

  task automatic test_short_glitch();
    do_reset();
    for (int e = 0; e <= 14; e++) begin
      bus.btn_in = (e < 3) ? 3'b100 : 3'b000;
      tick();
      vectors++;
      if (bus.btn_level !== 3'b000 || bus.btn_press !== 3'b000 || bus.btn_release !== 3'b000) begin
        miscompares++;
        $display("FAIL short_glitch e=%0d level=%b press=%b release=%b required all 000",
                 e, bus.btn_level, bus.btn_press, bus.btn_release);
      end
    end
  endtask

  task automatic test_release();
    logic [2:0] exp_l, exp_r;
    do_reset();
    bus.btn_in = 3'b010;
    for (int e = 0; e < 10; e++) tick();
    vectors++;
    if (bus.btn_level !== 3'b010) begin
      miscompares++;
      $display("FAIL release_setup level=%b req 010", bus.btn_level);
    end
    bus.btn_in = 3'b000;
    for (int e = 0; e <= 15; e++) begin
      tick();
      exp_l = (e >= 5) ? 3'b000 : 3'b010;
      exp_r = (e == 5) ? 3'b010 : 3'b000;
      vectors++;
      if (bus.btn_level !== exp_l || bus.btn_release !== exp_r || bus.btn_press !== 3'b000) begin
        miscompares++;
        $display("FAIL release e=%0d level=%b req %b release=%b req %b press=%b req 000",
                 e, bus.btn_level, exp_l, bus.btn_release, exp_r, bus.btn_press);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [2:0] exp_l, exp_p;
    do_reset();
    bus.btn_in = 3'b001;
    for (int e = 0; e <= 3; e++) tick();  // count has reached 2
    RST = 1'b1;
    tick();
    vectors++;
    if (bus.btn_level !== 3'b000 || bus.btn_press !== 3'b000 || bus.btn_release !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid_count_inreset level=%b press=%b release=%b required all 000",
               bus.btn_level, bus.btn_press, bus.btn_release);
    end
    RST = 1'b0;
    for (int e = 0; e <= 12; e++) begin
      tick();
      exp_l = (e >= 5) ? 3'b001 : 3'b000;
      exp_p = (e == 5) ? 3'b001 : 3'b000;
      vectors++;
      if (bus.btn_level !== exp_l || bus.btn_press !== exp_p || bus.btn_release !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_mid_count e=%0d level=%b req %b press=%b req %b release=%b req 000",
                 e, bus.btn_level, exp_l, bus.btn_press, exp_p, bus.btn_release);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp_l, exp_p;
    do_reset();
    bus.btn_in = 3'b101;
    for (int e = 0; e <= 10; e++) begin
      tick();
      exp_l = (e >= 5) ? 3'b101 : 3'b000;
      exp_p = (e == 5) ? 3'b101 : 3'b000;
      vectors++;
      if (bus.btn_level !== exp_l || bus.btn_press !== exp_p || bus.btn_release !== 3'b000) begin
        miscompares++;
        $display("FAIL simultaneous e=%0d level=%b req %b press=%b req %b release=%b req 000",
                 e, bus.btn_level, exp_l, bus.btn_press, exp_p, bus.btn_release);
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST         = 1'b1;
    bus.btn_in  = 3'b000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_glitch();
    test_release();
    test_reset_mid_count();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
